// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU run monitor: FSM state enum, register-index width
// and the expectation-table entry layout.
package cpu_mon_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned NREGS        = 1 << REG_W;
  // Entries store data zero-extended to this width, so DATA_W must not exceed it.
  localparam int unsigned EXP_DATA_MAX = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCheck,
    StDone
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [REG_W-1:0]        reg_idx;
    logic [EXP_DATA_MAX-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/cpu_halt_detect.sv
// Halt detector: pulses halt when pc has matched its previous-cycle value for
// HALT_CYCLES consecutive enabled cycles.
module cpu_halt_detect #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            halt
);

  localparam int unsigned CNT_W = $clog2(HALT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALT_CYCLES - 1);

  logic [PC_W-1:0]  prev_pc_q;
  logic [CNT_W-1:0] same_cnt_q;
  logic             same;

  assign same = (pc == prev_pc_q);
  assign halt = en && same && (same_cnt_q == LAST);

  // prev_pc tracks every cycle so the first enabled cycle compares against the start cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_q  <= '0;
      same_cnt_q <= '0;
    end else begin
      prev_pc_q <= pc;
      if (!en || !same) begin
        same_cnt_q <= '0;
      end else if (same_cnt_q != LAST) begin
        same_cnt_q <= same_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Snoops a CPU register-file write port during a run, detects halt or timeout,
// then checks the shadow registers against a loaded expectation table.
// Optional trace output is enabled with the CPU_RUN_MONITOR_TRACE_EN macro.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned NCHK        = 8,
  parameter int unsigned HALT_CYCLES = 4,
  parameter int unsigned MAX_CYCLES  = 4096,
  localparam int unsigned IDX_W      = (NCHK > 1) ? $clog2(NCHK) : 1,
  localparam int unsigned FC_W       = $clog2(NCHK + 1),
  localparam int unsigned CC_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic              rf_we,
  input  logic [REG_W-1:0]  rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [REG_W-1:0]  exp_reg,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [FC_W-1:0]   fail_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [CC_W-1:0]   cycle_count
);

  state_e            state_q;
  logic [DATA_W-1:0] shadow_q [NREGS];
  exp_entry_t        table_q  [NCHK];
  logic [IDX_W-1:0]  chk_idx_q;
  logic              halt;
  exp_entry_t        cur;
  logic              entry_fail;
  logic              last_entry;

  cpu_halt_detect #(
    .PC_W        (PC_W),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == StRun),
    .pc    (pc),
    .halt  (halt)
  );

  always_comb begin
    cur        = table_q[chk_idx_q];
    entry_fail = cur.valid && (cur.data != EXP_DATA_MAX'(shadow_q[cur.reg_idx]));
    last_entry = (chk_idx_q == IDX_W'(NCHK - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      cycle_count    <= '0;
      chk_idx_q      <= '0;
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NCHK; i++) table_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (exp_we && (32'(exp_idx) < NCHK)) begin
            table_q[exp_idx].valid   <= 1'b1;
            table_q[exp_idx].reg_idx <= exp_reg;
            table_q[exp_idx].data    <= EXP_DATA_MAX'(exp_data);
          end
          if (start) begin
            state_q        <= StRun;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            cycle_count    <= '0;
            chk_idx_q      <= '0;
            for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
          end
        end
        StRun: begin
          // r0 is hardwired to zero, so writes to it are dropped.
          if (rf_we && (rf_waddr != '0)) shadow_q[rf_waddr] <= rf_wdata;
          if (cycle_count != CC_W'(MAX_CYCLES)) cycle_count <= cycle_count + CC_W'(1);
          if (halt) begin
            state_q <= StCheck;
          end else if (cycle_count == CC_W'(MAX_CYCLES - 1)) begin
            timeout <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (entry_fail) begin
            fail_count <= fail_count + FC_W'(1);
            if (fail_count == '0) first_fail_idx <= chk_idx_q;
          end
          if (last_entry) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= !timeout && (fail_count == '0) && !entry_fail;
          end else begin
            chk_idx_q <= chk_idx_q + IDX_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CPU_RUN_MONITOR_TRACE_EN
  always @(posedge clk) begin
    if (!reset && (state_q == StRun) && rf_we && (rf_waddr != '0)) begin
      $display("[cpu_run_monitor] cycle=%0d pc=%h r%0d <= %h",
               cycle_count, pc, rf_waddr, rf_wdata);
    end
    if (!reset && (state_q == StCheck) && last_entry) begin
      $display("[cpu_run_monitor] done cycles=%0d timeout=%0b fail_count=%0d",
               cycle_count, timeout, fail_count + FC_W'(entry_fail));
    end
  end
`else
  // Trace disabled: the monitor produces no simulation output.
`endif

endmodule
